// File: rtl/field_step_pkg.sv
// field_step_pkg: shared types and constants for field_step_scanner.
//   state_t     - scanner FSM states (IDLE, SCAN, DONE)
//   DEF_*       - default parameter values (16-bit word, field [11:8])
//   field_mask  - 64-bit mask with bits [hi:lo] set
package field_step_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_LO    = 8;
    localparam int unsigned DEF_HI    = 11;

    function automatic logic [63:0] field_mask(input int unsigned hi, input int unsigned lo);
        logic [63:0] m;
        m = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            m[i] = (i >= lo) && (i <= hi);
        end
        return m;
    endfunction

endpackage

// File: rtl/field_step_scanner.sv
// field_step_scanner: advances bit-field [HI:LO] of a WIDTH-bit word to its
// next step (set the lowest zero bit in the field, clear every bit below it),
// scanning one field bit per cycle. Flags overflow when the field is all ones.
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid / in_ready  - request handshake (in_ready high only in IDLE)
//   a, dog               - operand word; dog=1 steps the field, dog=0 passes a
//   out_valid / out_ready- result handshake (out_valid high only in DONE)
//   mag                  - result word, held stable while out_valid
//   feeder               - overflow: field was all ones, no step possible
//
// Build option: define FIELD_STEP_WRAP_EN to return the field (and all bits
// below it) cleared on overflow; otherwise overflow returns a unchanged.
module field_step_scanner
    import field_step_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LO    = DEF_LO,
    parameter int unsigned HI    = DEF_HI
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic             dog,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mag,
    output logic             feeder
);

    localparam int unsigned     IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LO_IDX = IDX_W'(LO);
    localparam logic [IDX_W-1:0] HI_IDX = IDX_W'(HI);

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx,   w_idx_nxt;
    logic [WIDTH-1:0] r_a,     w_a_nxt;
    logic [WIDTH-1:0] r_mag,   w_mag_nxt;
    logic             r_feeder, w_feeder_nxt;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_ovf;

    // Step result for the current idx: above idx copied, idx set, below cleared.
    always_comb begin
        w_step = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_step[i] = (IDX_W'(i) > r_idx) ? r_a[i] : (IDX_W'(i) == r_idx);
        end
    end

`ifdef FIELD_STEP_WRAP_EN
    // Modular wrap: keep only the bits above HI.
    localparam logic [63:0]      CLR_MASK64 = field_mask(HI, 0);
    localparam logic [WIDTH-1:0] CLR_MASK   = CLR_MASK64[WIDTH-1:0];
    assign w_ovf = r_a & ~CLR_MASK;
`else
    assign w_ovf = r_a;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_a_nxt      = r_a;
        w_mag_nxt    = r_mag;
        w_feeder_nxt = r_feeder;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_a_nxt = a;
                    if (!dog) begin
                        w_mag_nxt    = a;
                        w_feeder_nxt = 1'b0;
                        w_state_nxt  = DONE;
                    end else begin
                        w_idx_nxt   = LO_IDX;
                        w_state_nxt = SCAN;
                    end
                end
            end
            SCAN: begin
                if (!r_a[r_idx]) begin
                    w_mag_nxt    = w_step;
                    w_feeder_nxt = 1'b0;
                    w_state_nxt  = DONE;
                end else if (r_idx == HI_IDX) begin
                    w_mag_nxt    = w_ovf;
                    w_feeder_nxt = 1'b1;
                    w_state_nxt  = DONE;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= LO_IDX;
            r_a      <= '0;
            r_mag    <= '0;
            r_feeder <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_a      <= w_a_nxt;
            r_mag    <= w_mag_nxt;
            r_feeder <= w_feeder_nxt;
        end
    end

    // Handshake outputs decode the registered state only, so DONE never
    // accepts a new request in the same cycle it hands off a result.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign mag       = r_mag;
    assign feeder    = r_feeder;

endmodule

// File: tb/tb_field_step_scanner.sv
module tb_field_step_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid0, in_valid1;
    logic [15:0] a;
    logic        dog;
    logic        out_ready;

    logic        in_ready0, out_valid0, feeder0;
    logic [15:0] mag0;
    logic        in_ready1, out_valid1, feeder1;
    logic [15:0] mag1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    field_step_scanner #(.WIDTH(16), .LO(8), .HI(11)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a), .dog(dog), .out_valid(out_valid0), .out_ready(out_ready),
        .mag(mag0), .feeder(feeder0)
    );

    field_step_scanner #(.WIDTH(16), .LO(0), .HI(0)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .dog(dog), .out_valid(out_valid1), .out_ready(out_ready),
        .mag(mag1), .feeder(feeder1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: stepping the field is +1 on the field value with the
    // carry confined to [hi:lo]; lower bits drop out via the shift.
    task automatic model(input int lo, input int hi, input logic [15:0] av, input logic dv,
                         output logic [15:0] m, output logic f, output int lat);
        int fm, field, k, keep;
        keep = 32'hFFFF & ~((1 << (hi + 1)) - 1);
        if (!dv) begin
            m = av; f = 1'b0; lat = 1;
            return;
        end
        fm    = (1 << (hi - lo + 1)) - 1;
        field = (int'(av) >> lo) & fm;
        if (field == fm) begin
            f   = 1'b1;
            lat = 2 + hi - lo;
`ifdef FIELD_STEP_WRAP_EN
            m = 16'(int'(av) & keep);
`else
            m = av;
`endif
        end else begin
            k = 0;
            while (((field >> k) & 1) == 1) k++;
            f   = 1'b0;
            lat = 2 + k;
            m   = 16'((int'(av) & keep) | (((field + 1) & fm) << lo));
        end
    endtask

    task automatic run(input int sel, input logic [15:0] av, input logic dv,
                       input logic [15:0] em, input logic ef, input int el, input string tag);
        int  lat;
        logic rdy, ov;
        rdy = 1'b0;
        for (int i = 0; i < 20 && !rdy; i++) begin
            @(negedge clk);
            rdy = (sel == 0) ? in_ready0 : in_ready1;
        end
        chk({tag, "_in_ready"}, 32'(rdy), 32'd1);
        a = av; dog = dv; out_ready = 1'b0;
        if (sel == 0) in_valid0 = 1'b1; else in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            ov = (sel == 0) ? out_valid0 : out_valid1;
            if (ov) lat = n;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(el));
        chk({tag, "_mag"}, 32'((sel == 0) ? mag0 : mag1), 32'(em));
        chk({tag, "_feeder"}, 32'((sel == 0) ? feeder0 : feeder1), 32'(ef));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        int          sel;
        logic [15:0] a;
        logic        dog;
        logic [15:0] mag;
        logic        fdr;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [15:0] rm, ra;
        logic        rf, rd;
        int          rl;

        vecs[0] = '{0, 16'h00FF, 1'b1, 16'h0100, 1'b0, 2};
        vecs[1] = '{0, 16'h0BFF, 1'b1, 16'h0C00, 1'b0, 4};
`ifdef FIELD_STEP_WRAP_EN
        vecs[2] = '{0, 16'h3F12, 1'b1, 16'h3000, 1'b1, 5};
        vecs[5] = '{1, 16'hFFFF, 1'b1, 16'hFFFE, 1'b1, 2};
`else
        vecs[2] = '{0, 16'h3F12, 1'b1, 16'h3F12, 1'b1, 5};
        vecs[5] = '{1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 2};
`endif
        vecs[3] = '{0, 16'h1234, 1'b0, 16'h1234, 1'b0, 1};
        vecs[4] = '{1, 16'hFFFE, 1'b1, 16'hFFFF, 1'b0, 2};

        rst = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0;
        a = '0; dog = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready0), 32'd1);
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_mag", 32'(mag0), 32'd0);
        chk("rst_feeder", 32'(feeder0), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run(vecs[i].sel, vecs[i].a, vecs[i].dog, vecs[i].mag, vecs[i].fdr, vecs[i].lat,
                $sformatf("vec%0d", i));
        end

        // Result held while consumer stalls; new requests ignored.
        @(negedge clk);
        a = 16'h1234; dog = 1'b0; in_valid0 = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        @(negedge clk);
        chk("hold_valid0", 32'(out_valid0), 32'd1);
        for (int i = 0; i < 3; i++) begin
            a = 16'hABCD; dog = 1'b1; in_valid0 = 1'b1;
            @(negedge clk);
            chk("hold_mag", 32'(mag0), 32'h1234);
            chk("hold_valid", 32'(out_valid0), 32'd1);
            chk("hold_in_ready", 32'(in_ready0), 32'd0);
            chk("hold_feeder", 32'(feeder0), 32'd0);
        end
        in_valid0 = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("hold_release_ready", 32'(in_ready0), 32'd1);
        chk("hold_release_valid", 32'(out_valid0), 32'd0);

        // Reset mid-scan aborts the request.
        a = 16'h0FFF; dog = 1'b1; in_valid0 = 1'b1;
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready0), 32'd1);
        chk("abort_out_valid", 32'(out_valid0), 32'd0);
        chk("abort_mag", 32'(mag0), 32'd0);
        chk("abort_feeder", 32'(feeder0), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_result", 32'(out_valid0), 32'd0);
        end
        out_ready = 1'b0;

        // Randomized requests against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra = ra | 16'h0F00;
            rd = ($urandom_range(0, 3) != 0);
            model(8, 11, ra, rd, rm, rf, rl);
            run(0, ra, rd, rm, rf, rl, "rand16");
        end
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rd = ($urandom_range(0, 3) != 0);
            model(0, 0, ra, rd, rm, rf, rl);
            run(1, ra, rd, rm, rf, rl, "rand_lo0");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
